tdm_demux8_rx: RTL and testbench

//   Receive end of the 8:1 mux serial path: a clocked 1:8 time-division demultiplexer.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_counter.sv | 29 ++
 rtl/tdm_demux8_rx.sv | 142 ++++++++++++++
 tb/tb_tdm_demux8_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive demultiplexer.
// The slot count is the default frame width; the state enum is used by the top FSM.
package tdm_pkg;

   localparam int TDM_N_SLOTS = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: advances on a strobe, reloads to 1 when a sync strobe is taken as slot 0.
// Wraps naturally because the slot count is a power of two.
module tdm_slot_counter #(
   parameter int SEL_W = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_load1,
   output logic [SEL_W-1:0] o_cnt,
   output logic             o_wrap
);

   logic [SEL_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load1) begin
         r_cnt <= SEL_W'(1);
      end else if (i_inc) begin
         r_cnt <= r_cnt + SEL_W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_wrap = &r_cnt;

endmodule

// File: rtl/tdm_demux8_rx.sv
// 1:N time-division demultiplexer: steers one serial bit per strobe into its slot,
// assembles full frames and hands them off over a valid/ready holding stage.
//
//   state | meaning
//   IDLE  | unsynchronised; strobes ignored until one arrives with sync
//   RUN   | locked; every strobe captures into slot sel
module tdm_demux8_rx
   import tdm_pkg::*;
#(
   parameter int N_SLOTS = TDM_N_SLOTS
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_sync,
   input  logic                       i_din,
   output logic [$clog2(N_SLOTS)-1:0] o_sel,
   output logic [N_SLOTS-1:0]         o_y,
   output logic [N_SLOTS-1:0]         o_frame,
   output logic                       o_frame_valid,
   input  logic                       i_frame_ready,
   output logic                       o_overrun,
   output logic                       o_resync_err
);

   localparam int SEL_W = $clog2(N_SLOTS);

   if (N_SLOTS < 2 || (N_SLOTS & (N_SLOTS - 1)) != 0) begin : g_bad_slots
      $error("tdm_demux8_rx: N_SLOTS must be a power of two and at least 2");
   end

   tdm_state_e         r_state;
   tdm_state_e         w_state_next;
   logic               w_capture;
   logic               w_load;
   logic               w_resync;
   logic               w_complete;
   logic [SEL_W-1:0]   w_sel;
   logic [SEL_W-1:0]   w_slot;
   logic               w_wrap;
   logic [N_SLOTS-1:0] w_asm_next;
   logic [N_SLOTS-1:0] r_asm;
   logic [N_SLOTS-1:0] r_y;
   logic [N_SLOTS-1:0] r_frame;
   logic               r_frame_valid;
   logic               r_overrun;
   logic               r_resync_err;

   tdm_slot_counter #(
      .SEL_W (SEL_W)
   ) u_slot_counter (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (w_capture && !w_load),
      .i_load1 (w_load),
      .o_cnt   (w_sel),
      .o_wrap  (w_wrap)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_load       = 1'b0;
      w_resync     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_en && i_sync) begin
               w_capture    = 1'b1;
               w_load       = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            if (i_en) begin
               w_capture = 1'b1;
               if (i_sync) begin
                  w_load   = 1'b1;
                  w_resync = (w_sel != '0);
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // A sync strobe always lands in slot 0, whatever the counter says.
   assign w_slot     = w_load ? '0 : w_sel;
   assign w_complete = w_capture && !w_load && w_wrap;

   // Slot 0 starts a fresh assembly so a discarded partial frame leaves no residue.
   always_comb begin
      w_asm_next = r_asm;
      if (w_slot == '0) begin
         w_asm_next = '0;
      end
      w_asm_next[w_slot] = i_din;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_asm         <= '0;
         r_y           <= '0;
         r_frame       <= '0;
         r_frame_valid <= 1'b0;
         r_overrun     <= 1'b0;
         r_resync_err  <= 1'b0;
      end else begin
         r_overrun    <= 1'b0;
         r_resync_err <= w_resync;
         if (w_capture) begin
            r_y[w_slot] <= i_din;
            r_asm       <= w_asm_next;
         end
         if (w_complete) begin
            if (!r_frame_valid || i_frame_ready) begin
               r_frame       <= w_asm_next;
               r_frame_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_frame_valid && i_frame_ready) begin
            r_frame_valid <= 1'b0;
         end
      end
   end

   assign o_sel         = w_sel;
   assign o_y           = r_y;
   assign o_frame       = r_frame;
   assign o_frame_valid = r_frame_valid;
   assign o_overrun     = r_overrun;
   assign o_resync_err  = r_resync_err;

endmodule

// File: tb/tb_tdm_demux8_rx.sv
// Randomised and directed bench for tdm_demux8_rx with a slot-level reference model
// and a scoreboard monitor for handed-off frames and error pulses.
module tb_tdm_demux8_rx;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_en = 1'b0;
   logic       i_sync = 1'b0;
   logic       i_din = 1'b0;
   logic       i_frame_ready = 1'b0;
   logic [2:0] o_sel;
   logic [7:0] o_y;
   logic [7:0] o_frame;
   logic       o_frame_valid;
   logic       o_overrun;
   logic       o_resync_err;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   int exp_frames[$];
   int exp_ovr[$];
   int exp_rse[$];

   bit       m_locked;
   int       m_slot;
   bit       m_bits[8];
   bit [7:0] m_y;
   bit [7:0] m_frame;
   bit       m_valid;

   tdm_demux8_rx dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_en          (i_en),
      .i_sync        (i_sync),
      .i_din         (i_din),
      .o_sel         (o_sel),
      .o_y           (o_y),
      .o_frame       (o_frame),
      .o_frame_valid (o_frame_valid),
      .i_frame_ready (i_frame_ready),
      .o_overrun     (o_overrun),
      .o_resync_err  (o_resync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit [7:0] bits_value();
      bit [7:0] v = '0;
      for (int k = 0; k < 8; k++) v[k] = m_bits[k];
      return v;
   endfunction

   task automatic model_reset();
      m_locked = 0;
      m_slot   = 0;
      m_y      = '0;
      m_frame  = '0;
      m_valid  = 0;
      for (int k = 0; k < 8; k++) m_bits[k] = 0;
      exp_frames.delete();
   endtask

   task automatic start_slot0(input bit din);
      for (int k = 0; k < 8; k++) m_bits[k] = 0;
      m_bits[0] = din;
      m_y[0]    = din;
      m_slot    = 1;
   endtask

   // Predicts the effect of the coming clock edge from the slot-level rules.
   task automatic model_next(input bit en, input bit sync, input bit din, input bit rdy);
      bit complete = 0;
      if (en) begin
         if (!m_locked) begin
            if (sync) begin
               m_locked = 1;
               start_slot0(din);
            end
         end else if (sync && m_slot != 0) begin
            exp_rse.push_back(cyc + 1);
            start_slot0(din);
         end else if (m_slot == 0) begin
            start_slot0(din);
         end else begin
            m_bits[m_slot] = din;
            m_y[m_slot]    = din;
            complete       = (m_slot == 7);
            m_slot         = (m_slot + 1) % 8;
         end
      end
      if (complete) begin
         if (!m_valid || rdy) begin
            m_frame = bits_value();
            m_valid = 1;
            exp_frames.push_back(int'(m_frame));
         end else begin
            exp_ovr.push_back(cyc + 1);
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
   endtask

   task automatic step(input bit en, input bit sync, input bit din, input bit rdy);
      chk("sel", int'(o_sel), m_slot);
      chk("y", int'(o_y), int'(m_y));
      chk("frame_valid", int'(o_frame_valid), int'(m_valid));
      chk("frame", int'(o_frame), int'(m_frame));
      i_rst         = 1'b0;
      i_en          = en;
      i_sync        = sync;
      i_din         = din;
      i_frame_ready = rdy;
      model_next(en, sync, din, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst         = 1'b1;
      i_en          = 1'b1;
      i_sync        = 1'b1;
      i_din         = 1'b1;
      i_frame_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic send_frame(input bit [7:0] v, input bit [7:0] rmask);
      for (int k = 0; k < 8; k++) step(1'b1, k == 0, v[k], rmask[k]);
   endtask

   // Monitor: inputs are stable at the falling edge, so valid&&ready here means a transfer.
   always @(negedge clk) begin
      if (o_overrun === 1'b1) begin
         if (exp_ovr.size() == 0) chk("overrun_unexpected", 1, 0);
         else chk("overrun_cycle", cyc, exp_ovr.pop_front());
      end
      if (o_resync_err === 1'b1) begin
         if (exp_rse.size() == 0) chk("resync_unexpected", 1, 0);
         else chk("resync_cycle", cyc, exp_rse.pop_front());
      end
      if (i_rst === 1'b0 && o_frame_valid === 1'b1 && i_frame_ready === 1'b1) begin
         if (exp_frames.size() == 0) chk("frame_unexpected", int'(o_frame), -1);
         else chk("frame_xfer", int'(o_frame), exp_frames.pop_front());
      end
   end

   initial begin
      bit en, sync, rdy;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // slot order 0,0,1,1,1,0,0,1 assembles 8'h9C
      send_frame(8'h9C, 8'hFF);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // unsynchronised strobes are ignored, then sync locks
      do_reset();
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b1);
      send_frame(8'h6B, 8'hFF);

      // stalled consumer: second frame dropped with overrun, first one held
      send_frame(8'hA5, 8'h00);
      send_frame(8'h3C, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // transfer coincides with completion: back-to-back, no bubble
      send_frame(8'h5A, 8'h00);
      send_frame(8'h3C, 8'h80);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // sync on the 4th strobe discards the partial frame
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      for (int k = 1; k < 8; k++) step(1'b1, 1'b0, k[0], 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // reset with sel=5 and a frame pending
      send_frame(8'hC3, 8'h00);
      for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1, 1'b0);
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 1'b1);

      // randomised traffic
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            en   = ($urandom_range(0, 3) != 0);
            sync = (m_slot == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 23) == 0);
            rdy  = ($urandom_range(0, 2) != 0);
            step(en, sync, 1'($urandom), rdy);
         end
      end

      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("frames_left", exp_frames.size(), 0);
      chk("overruns_left", exp_ovr.size(), 0);
      chk("resyncs_left", exp_rse.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
